// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// VGA 640x480 @ 60 Hz timing generator.
// It divides the system clock by DIV to produce the pixel rate.
// It runs the horizontal and vertical pixel counters.
// It drives the active-low sync pulses, the video_on qualifier and a
// frame_end strobe for the text pixel generator.
//
// Every output is a register. The sync outputs, video_on, p_tick and
// frame_end are all computed from the *next* counter values. As a result,
// every output describes the same pixel in the same clk cycle.
//
// Ports
//   clk        in   system clock (100 MHz)
//   reset_n    in   asynchronous, active-low reset
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  current pixel lies inside the visible area
//   p_tick     out  one-clk pixel strobe, once every DIV clocks
//   pixel_x    out  horizontal counter, 0 .. H_TOT-1
//   pixel_y    out  vertical counter,   0 .. V_TOT-1
//   frame_end  out  one-clk pulse while the last pixel of a frame is shown
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int DIV    = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  // Current state registers
  logic [DIV_W-1:0] div_cnt_r;
  logic [9:0]       x_r;
  logic [9:0]       y_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             video_on_r;
  logic             p_tick_r;
  logic             frame_end_r;

  // Next-state values
  logic [DIV_W-1:0] div_cnt_s;
  logic [9:0]       x_s;
  logic [9:0]       y_s;
  logic             pix_adv_s;
  logic             line_wrap_s;
  logic             hsync_s;
  logic             vsync_s;
  logic             video_on_s;
  logic             p_tick_s;
  logic             frame_end_s;

  // Pixel-rate divider: the counters step on the edge that ends a p_tick cycle.
  always_comb begin
    div_cnt_s = div_cnt_r;
    pix_adv_s = (div_cnt_r == DIV_LAST);
    if (pix_adv_s) begin
      div_cnt_s = '0;
    end else begin
      div_cnt_s = div_cnt_r + DIV_ONE;
    end
  end

  // Horizontal and vertical next-count.
  // y only moves on the edge where x wraps.
  always_comb begin
    x_s         = x_r;
    y_s         = y_r;
    line_wrap_s = pix_adv_s && (x_r == H_LAST);
    if (pix_adv_s) begin
      if (line_wrap_s) begin
        x_s = 10'd0;
      end else begin
        x_s = x_r + 10'd1;
      end
    end else begin
      x_s = x_r;
    end
    if (line_wrap_s) begin
      if (y_r == V_LAST) begin
        y_s = 10'd0;
      end else begin
        y_s = y_r + 10'd1;
      end
    end else begin
      y_s = y_r;
    end
  end

  // Decode the outputs from the next counter values.
  // This keeps them aligned with pixel_x/pixel_y, with no extra cycle of lag.
  always_comb begin
    hsync_s     = !((x_s >= H_SYNC_FIRST) && (x_s <= H_SYNC_LAST));
    vsync_s     = !((y_s >= V_SYNC_FIRST) && (y_s <= V_SYNC_LAST));
    video_on_s  = (x_s < H_VIS_END) && (y_s < V_VIS_END);
    p_tick_s    = (div_cnt_s == DIV_LAST);
    frame_end_s = p_tick_s && (x_s == H_LAST) && (y_s == V_LAST);
  end

  // State and output registers, with asynchronous reset to the idle pixel (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r   <= '0;
      x_r         <= 10'd0;
      y_r         <= 10'd0;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
      video_on_r  <= 1'b0;
      p_tick_r    <= 1'b0;
      frame_end_r <= 1'b0;
    end else begin
      div_cnt_r   <= div_cnt_s;
      x_r         <= x_s;
      y_r         <= y_s;
      hsync_r     <= hsync_s;
      vsync_r     <= vsync_s;
      video_on_r  <= video_on_s;
      p_tick_r    <= p_tick_s;
      frame_end_r <= frame_end_s;
    end
  end

  assign hsync     = hsync_r;
  assign vsync     = vsync_r;
  assign video_on  = video_on_r;
  assign p_tick    = p_tick_r;
  assign pixel_x   = x_r;
  assign pixel_y   = y_r;
  assign frame_end = frame_end_r;

  vga_sync_gen_chk #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .hsync     (hsync_r),
    .vsync     (vsync_r),
    .video_on  (video_on_r),
    .p_tick    (p_tick_r),
    .pixel_x   (x_r),
    .pixel_y   (y_r),
    .frame_end (frame_end_r)
  );

endmodule

// ---------------------------------------------------------------------------
// vga_sync_gen_chk
//
// Consistency properties between the registered counters and the decoded
// outputs of vga_sync_gen. All ports are inputs, and the module holds no
// state of its own.
//
// Ports
//   clk, reset_n                 clock and asynchronous active-low reset
//   hsync, vsync, video_on       decoded outputs under observation
//   p_tick, frame_end            strobes under observation
//   pixel_x, pixel_y             counters under observation
// ---------------------------------------------------------------------------
module vga_sync_gen_chk #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input logic       clk,
  input logic       reset_n,
  input logic       hsync,
  input logic       vsync,
  input logic       video_on,
  input logic       p_tick,
  input logic [9:0] pixel_x,
  input logic [9:0] pixel_y,
  input logic       frame_end
);

  localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  a_x_range : assert property (@(posedge clk) disable iff (!reset_n)
    pixel_x <= H_LAST)
    else $error("vga_sync_gen_chk: pixel_x out of range");

  a_y_range : assert property (@(posedge clk) disable iff (!reset_n)
    pixel_y <= V_LAST)
    else $error("vga_sync_gen_chk: pixel_y out of range");

  a_hsync : assert property (@(posedge clk) disable iff (!reset_n)
    hsync == !((pixel_x >= H_SYNC_FIRST) && (pixel_x <= H_SYNC_LAST)))
    else $error("vga_sync_gen_chk: hsync disagrees with pixel_x");

  a_vsync : assert property (@(posedge clk) disable iff (!reset_n)
    vsync == !((pixel_y >= V_SYNC_FIRST) && (pixel_y <= V_SYNC_LAST)))
    else $error("vga_sync_gen_chk: vsync disagrees with pixel_y");

  a_video : assert property (@(posedge clk) disable iff (!reset_n)
    video_on |-> ((pixel_x < H_VIS_END) && (pixel_y < V_VIS_END)))
    else $error("vga_sync_gen_chk: video_on outside visible area");

  a_frame_end : assert property (@(posedge clk) disable iff (!reset_n)
    frame_end |-> (p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST)))
    else $error("vga_sync_gen_chk: frame_end away from last pixel");

endmodule
